// File: rtl/control_humedad_pkg.sv
// Shared constants and types for the soil-moisture controller:
// ADC receiver state encoding, frame layout and default thresholds.
package control_humedad_pkg;

    // ADC receiver states (2-bit encoding)
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCsSetup = 2'd1,
        StShift   = 2'd2,
        StDone    = 2'd3
    } rx_state_e;

    // ADC frame: start bit, null bit, then 8 data bits MSB first
    localparam int unsigned FRAME_BITS   = 10;
    localparam int unsigned DISCARD_BITS = 2;
    localparam int unsigned DATA_BITS    = 8;
    // Every SCLK edge of the frame is one half-period
    localparam int unsigned HALF_PERIODS = 2 * FRAME_BITS;

    // Default thresholds (higher code = drier soil)
    localparam logic [7:0] UMBRAL_SECO_DEF   = 8'd160;
    localparam logic [7:0] UMBRAL_HUMEDO_DEF = 8'd100;

    // Increment that sticks at the limit instead of wrapping
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/control_humedad_adc_rx.sv
// Serial ADC receiver: drives CS and SCLK for one 10-bit frame, drops the
// start/null bits and shifts the 8 data bits in MSB first.
module adc_serial_rx
    import control_humedad_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_adc_do,
    output logic       o_cs_n,
    output logic       o_sclk,
    output logic       o_done,
    output logic [7:0] o_dato
);

    localparam int unsigned DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    rx_state_e      r_state, w_state_d;
    logic [DW-1:0]  r_div, w_div_d;
    logic [4:0]     r_half, w_half_d;
    logic           r_sclk, w_sclk_d;
    logic           r_cs_n, w_cs_n_d;
    logic [7:0]     r_shift, w_shift_d;
    logic           w_div_end;

    assign w_div_end = (r_div == DW'(SCLK_DIV - 1));

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_half  <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_shift <= '0;
        end else begin
            r_state <= w_state_d;
            r_div   <= w_div_d;
            r_half  <= w_half_d;
            r_sclk  <= w_sclk_d;
            r_cs_n  <= w_cs_n_d;
            r_shift <= w_shift_d;
        end
    end

    // Next-state: one half-period of setup, 20 SCLK toggles, one trailing low half-period
    always_comb begin
        w_state_d = r_state;
        w_div_d   = r_div;
        w_half_d  = r_half;
        w_sclk_d  = r_sclk;
        w_cs_n_d  = r_cs_n;
        w_shift_d = r_shift;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_cs_n_d  = 1'b0;
                    w_div_d   = '0;
                    w_half_d  = '0;
                    w_state_d = StCsSetup;
                end
            end
            StCsSetup: begin
                if (w_div_end) begin
                    w_div_d   = '0;
                    w_state_d = StShift;
                end else begin
                    w_div_d = r_div + 1'b1;
                end
            end
            StShift: begin
                if (w_div_end) begin
                    w_div_d = '0;
                    if (r_half == 5'(HALF_PERIODS)) begin
                        w_state_d = StDone;
                    end else begin
                        w_sclk_d = ~r_sclk;
                        w_half_d = r_half + 5'd1;
                        // Capture on the 0->1 edge; the first two captures are framing bits
                        if (!r_sclk && (r_half >= 5'(2 * DISCARD_BITS))) begin
                            w_shift_d = {r_shift[DATA_BITS-2:0], i_adc_do};
                        end
                    end
                end else begin
                    w_div_d = r_div + 1'b1;
                end
            end
            StDone: begin
                w_cs_n_d  = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_cs_n = r_cs_n;
    assign o_sclk = r_sclk;
    assign o_done = (r_state == StDone);
    assign o_dato = r_shift;

endmodule

// File: rtl/control_humedad.sv
// Soil-moisture front end: periodically converts the probe ADC and drives
// `activar` through hysteresis thresholds plus an N-sample confirmation.
module control_humedad
    import control_humedad_pkg::*;
#(
    parameter int unsigned SCLK_DIV      = 50,
    parameter int unsigned SAMPLE_PERIOD = 50_000_000,
    parameter logic [7:0]  UMBRAL_SECO   = UMBRAL_SECO_DEF,
    parameter logic [7:0]  UMBRAL_HUMEDO = UMBRAL_HUMEDO_DEF,
    parameter int unsigned N_CONFIRM     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adc_do,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] muestra,
    output logic       muestra_valida,
    output logic       activar
);

    localparam int unsigned PW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [3:0]  LIM = 4'(N_CONFIRM);

    logic [PW-1:0] r_period;
    logic          w_start;
    logic          w_done;
    logic [7:0]    w_dato;
    logic          w_seco;
    logic          w_humedo;

    logic [7:0]    r_muestra, w_muestra_d;
    logic          r_valida, w_valida_d;
    logic          r_activar, w_activar_d;
    logic [3:0]    r_cnt_seco, w_cnt_seco_d;
    logic [3:0]    r_cnt_humedo, w_cnt_humedo_d;

    // Start-to-start period: count zero fires a conversion, so the first one
    // starts on the first edge after reset release
    assign w_start = (r_period == '0);

    // Free-running period counter, keeps counting through conversions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
        end else if (r_period == PW'(SAMPLE_PERIOD - 1)) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

    adc_serial_rx #(
        .SCLK_DIV (SCLK_DIV)
    ) u_adc_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_adc_do (adc_do),
        .o_cs_n   (adc_cs_n),
        .o_sclk   (adc_sclk),
        .o_done   (w_done),
        .o_dato   (w_dato)
    );

    assign w_seco   = (w_dato >= UMBRAL_SECO);
    assign w_humedo = (w_dato <= UMBRAL_HUMEDO);

    // Filter next-state: evaluated only on the frame-done cycle so activar cannot glitch
    always_comb begin
        w_muestra_d     = r_muestra;
        w_valida_d      = 1'b0;
        w_activar_d     = r_activar;
        w_cnt_seco_d    = r_cnt_seco;
        w_cnt_humedo_d  = r_cnt_humedo;
        if (w_done) begin
            w_muestra_d = w_dato;
            w_valida_d  = 1'b1;
            if (w_seco) begin
                w_cnt_seco_d   = sat_inc(r_cnt_seco, LIM);
                w_cnt_humedo_d = '0;
                if (w_cnt_seco_d == LIM) begin
                    w_activar_d = 1'b1;
                end
            end else if (w_humedo) begin
                w_cnt_humedo_d = sat_inc(r_cnt_humedo, LIM);
                w_cnt_seco_d   = '0;
                if (w_cnt_humedo_d == LIM) begin
                    w_activar_d = 1'b0;
                end
            end else begin
                // Dead band breaks any run on either side
                w_cnt_seco_d   = '0;
                w_cnt_humedo_d = '0;
            end
        end
    end

    // Sample, strobe and filter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_muestra    <= '0;
            r_valida     <= 1'b0;
            r_activar    <= 1'b0;
            r_cnt_seco   <= '0;
            r_cnt_humedo <= '0;
        end else begin
            r_muestra    <= w_muestra_d;
            r_valida     <= w_valida_d;
            r_activar    <= w_activar_d;
            r_cnt_seco   <= w_cnt_seco_d;
            r_cnt_humedo <= w_cnt_humedo_d;
        end
    end

    assign muestra        = r_muestra;
    assign muestra_valida = r_valida;
    assign activar        = r_activar;

endmodule

// File: tb/tb_control_humedad.sv
// Bench for control_humedad: behavioural serial ADC, history-based filter model,
// directed plan steps followed by random samples.
module tb_control_humedad;

    localparam int         DIV  = 2;
    localparam int         PER  = 100;
    localparam int         NC   = 3;
    localparam logic [7:0] SECO = 8'd160;
    localparam logic [7:0] HUM  = 8'd100;
    localparam int         LAT  = 22 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       adc_do = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] muestra;
    logic       muestra_valida;
    logic       activar;

    control_humedad #(
        .SCLK_DIV      (DIV),
        .SAMPLE_PERIOD (PER),
        .UMBRAL_SECO   (SECO),
        .UMBRAL_HUMEDO (HUM),
        .N_CONFIRM     (NC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc_do         (adc_do),
        .adc_cs_n       (adc_cs_n),
        .adc_sclk       (adc_sclk),
        .muestra        (muestra),
        .muestra_valida (muestra_valida),
        .activar        (activar)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Posedge counter, read only at negedges
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor sampled at the falling clock edge
    int   cs_fall_cyc = 0;
    int   cs_falls = 0;
    int   sclk_rises = 0;
    int   valid_cyc = 0;
    int   valid_count = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
            cs_fall_cyc = cyc;
            cs_falls++;
            sclk_rises = 0;
        end
        if (prev_sclk === 1'b0 && adc_sclk === 1'b1) sclk_rises++;
        if (muestra_valida === 1'b1) begin
            valid_cyc = cyc;
            valid_count++;
        end
        prev_cs = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    // ADC model: frame = start(1), null(0), data MSB first; new bit after each SCLK fall
    logic [7:0] adc_value = 8'h00;
    logic [9:0] frame = '0;
    int         bit_idx = 0;
    always @(negedge adc_cs_n) begin
        frame = {2'b10, adc_value};
        bit_idx = 0;
        adc_do = frame[9];
    end
    always @(negedge adc_sclk) begin
        if (adc_cs_n === 1'b0) begin
            bit_idx++;
            adc_do = (bit_idx < 10) ? frame[9 - bit_idx] : 1'b0;
        end
    end

    // Reference: activar follows the last NC samples when they all sit on one side
    logic [7:0] hist[$];
    logic       model_act = 1'b0;
    task automatic model_push(input logic [7:0] v);
        bit all_dry;
        bit all_wet;
        hist.push_back(v);
        if (hist.size() >= NC) begin
            all_dry = 1;
            all_wet = 1;
            for (int i = hist.size() - NC; i < hist.size(); i++) begin
                if (hist[i] < SECO) all_dry = 0;
                if (hist[i] > HUM) all_wet = 0;
            end
            if (all_dry) model_act = 1'b1;
            else if (all_wet) model_act = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cs_fall(input int base, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cs_falls != base) begin
                ok = 1;
                break;
            end
        end
    endtask

    // One conversion: present v, wait for the strobe, compare against the model
    task automatic conv(input logic [7:0] v, input string tag);
        bit ok;
        int base;
        base = valid_count;
        adc_value = v;
        ok = 0;
        for (int i = 0; i < 4 * PER; i++) begin
            tick();
            if (valid_count != base) begin
                ok = 1;
                break;
            end
        end
        check({tag, " strobe seen"}, 32'(ok), 32'd1);
        if (ok) begin
            model_push(v);
            check({tag, " muestra"}, 32'(muestra), 32'(v));
            check({tag, " activar"}, 32'(activar), 32'(model_act));
            check({tag, " sclk rises"}, 32'(sclk_rises), 32'd10);
            check({tag, " latency"}, 32'(valid_cyc - cs_fall_cyc), 32'(LAT));
            tick();
            check({tag, " strobe width"}, 32'(muestra_valida), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         rel;
        int         first_fall;
        int         base;
        int         vc;
        logic [7:0] v;

        adc_value = 8'hA5;
        repeat (3) tick();
        check("reset cs_n", 32'(adc_cs_n), 32'd1);
        check("reset sclk", 32'(adc_sclk), 32'd0);
        check("reset muestra", 32'(muestra), 32'd0);
        check("reset valida", 32'(muestra_valida), 32'd0);
        check("reset activar", 32'(activar), 32'd0);

        // Release and expect CS to fall on the very next edge
        rel = cyc;
        rst_n = 1'b1;
        wait_cs_fall(0, 10, ok);
        check("first cs fall", 32'(cs_fall_cyc - rel), 32'd1);
        first_fall = cs_fall_cyc;
        conv(8'hA5, "a5");

        // Next start 100 cycles after the first
        adc_value = 8'd130;
        wait_cs_fall(1, 2 * PER, ok);
        check("period", 32'(cs_fall_cyc - first_fall), 32'(PER));
        conv(8'd130, "dead0");

        for (int i = 0; i < 3; i++) conv(8'd170, "dry170");
        conv(8'd90, "wet90a");
        conv(8'd90, "wet90b");
        conv(8'd130, "dead130");
        for (int i = 0; i < 3; i++) conv(8'd90, "wet90c");
        for (int i = 0; i < 3; i++) conv(8'd160, "edge160");
        for (int i = 0; i < 3; i++) conv(8'd100, "edge100");
        for (int i = 0; i < 10; i++) conv(8'd170, "sat170");

        // Abort a conversion after the 5th SCLK rising edge
        adc_value = 8'h3C;
        base = cs_falls;
        ok = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            tick();
            if (cs_falls != base && sclk_rises >= 5) begin
                ok = 1;
                break;
            end
        end
        check("abort point reached", 32'(ok), 32'd1);
        vc = valid_count;
        rst_n = 1'b0;
        #1;
        check("abort cs_n", 32'(adc_cs_n), 32'd1);
        check("abort sclk", 32'(adc_sclk), 32'd0);
        check("abort muestra", 32'(muestra), 32'd0);
        check("abort activar", 32'(activar), 32'd0);
        repeat (3) tick();
        check("abort no strobe", 32'(valid_count - vc), 32'd0);
        hist.delete();
        model_act = 1'b0;

        adc_value = 8'h5A;
        base = cs_falls;
        rel = cyc;
        rst_n = 1'b1;
        wait_cs_fall(base, 10, ok);
        check("restart cs fall", 32'(cs_fall_cyc - rel), 32'd1);
        conv(8'h5A, "restart");

        // Random samples, biased toward runs so activar actually moves
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    v = 8'($urandom_range(160, 255));
                2, 3:    v = 8'($urandom_range(0, 100));
                default: v = 8'($urandom_range(101, 159));
            endcase
            conv(v, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
